// File: rtl/fpu_pkg.sv
// Shared single-precision constants, rounding-mode encoding and small
// helpers used by the rounding datapath and its pipeline wrapper.
package fpu_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;
  localparam int QNAN_BIT = 22;

  typedef enum logic [1:0] {
    RM_FLOOR = 2'd0,
    RM_CEIL  = 2'd1,
    RM_TRUNC = 2'd2,
    RM_RNE   = 2'd3
  } round_mode_e;

  // Signed 1.0 in single precision.
  function automatic logic [31:0] fp_one(input logic sign);
    return {sign, EXP_W'(EXP_BIAS), {MANT_W{1'b0}}};
  endfunction

  // Signed zero in single precision.
  function automatic logic [31:0] fp_zero(input logic sign);
    return {sign, {(EXP_W + MANT_W){1'b0}}};
  endfunction

endpackage

// File: rtl/fround_calc.sv
// Combinational round-to-integral of one IEEE-754 single operand.
// Values with |x| >= 2^23 are already integral; values with |x| < 1 collapse
// to a signed 0 or 1; everything else drops the fractional mantissa bits and
// optionally adds one unit in the last integral place.
module fround_calc
  import fpu_pkg::*;
(
  input  logic [31:0] x,
  input  round_mode_e mode,
  output logic [31:0] y,
  output logic        inexact
);

  localparam logic [EXP_W-1:0]  EXP_MAX  = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0]  EXP_ZERO = {EXP_W{1'b0}};
  localparam logic [EXP_W-1:0]  EXP_PASS = EXP_W'(EXP_BIAS + MANT_W);
  localparam logic [EXP_W-1:0]  EXP_ONE  = EXP_W'(EXP_BIAS);
  localparam logic [EXP_W-1:0]  EXP_HALF = EXP_W'(EXP_BIAS - 1);
  localparam logic [EXP_W-1:0]  EXP_INC  = 8'd1;
  localparam logic [MANT_W:0]   SIG_LSB  = 24'd1;
  localparam logic [MANT_W:0]   SIG_ZERO = 24'd0;
  localparam logic [MANT_W-1:0] MAN_ZERO = 23'd0;

  logic                sign_s;
  logic [EXP_W-1:0]    exp_s;
  logic [MANT_W-1:0]   man_s;
  logic [EXP_W-1:0]    shift_s;
  logic [MANT_W:0]     sig_s;
  logic [MANT_W:0]     ulp_s;
  logic [MANT_W:0]     mask_s;
  logic [MANT_W:0]     frac_s;
  logic [MANT_W:0]     half_s;
  logic                lsb_s;
  logic                up_s;
  logic [MANT_W+1:0]   sum_s;

  // Split the operand, pick the rounding increment and build the result
  always_comb begin
    sign_s  = x[31];
    exp_s   = x[30:MANT_W];
    man_s   = x[MANT_W-1:0];
    shift_s = EXP_PASS - exp_s;          // number of fractional mantissa bits
    sig_s   = {1'b1, man_s};
    ulp_s   = SIG_LSB << shift_s;        // weight of the integral LSB
    mask_s  = ulp_s - SIG_LSB;
    frac_s  = sig_s & mask_s;
    half_s  = ulp_s >> 1'b1;
    lsb_s   = |(sig_s & ulp_s);

    case (mode)
      RM_FLOOR: up_s = sign_s && (frac_s != SIG_ZERO);
      RM_CEIL:  up_s = !sign_s && (frac_s != SIG_ZERO);
      RM_TRUNC: up_s = 1'b0;
      RM_RNE:   up_s = (frac_s > half_s) || ((frac_s == half_s) && lsb_s);
      default:  up_s = 1'b0;
    endcase

    sum_s   = {1'b0, sig_s & ~mask_s} + {1'b0, (up_s ? ulp_s : SIG_ZERO)};
    y       = x;
    inexact = 1'b0;

    if (exp_s == EXP_MAX) begin
      // infinities pass; NaNs come back quiet
      if (man_s != MAN_ZERO) begin
        y[QNAN_BIT] = 1'b1;
      end else begin
        y = x;
      end
    end else if (exp_s >= EXP_PASS) begin
      y = x;
    end else if (exp_s == EXP_ZERO) begin
      // zeros and flushed denormals
      y       = fp_zero(sign_s);
      inexact = (man_s != MAN_ZERO);
    end else if (exp_s < EXP_ONE) begin
      // 0 < |x| < 1: result is a signed 0 or a signed 1
      inexact = 1'b1;
      case (mode)
        RM_FLOOR: y = sign_s ? fp_one(1'b1) : fp_zero(1'b0);
        RM_CEIL:  y = sign_s ? fp_zero(1'b1) : fp_one(1'b0);
        RM_TRUNC: y = fp_zero(sign_s);
        RM_RNE:   y = ((exp_s == EXP_HALF) && (man_s != MAN_ZERO)) ? fp_one(sign_s) : fp_zero(sign_s);
        default:  y = fp_zero(sign_s);
      endcase
    end else begin
      inexact = (frac_s != SIG_ZERO);
      // a carry out of the significand bumps the exponent
      if (sum_s[MANT_W+1]) begin
        y = {sign_s, exp_s + EXP_INC, sum_s[MANT_W:1]};
      end else begin
        y = {sign_s, exp_s, sum_s[MANT_W-1:0]};
      end
    end
  end

endmodule

// File: rtl/fround_pipe.sv
// Valid/ready pipeline around fround_calc. Stage 0 captures the rounded
// result; later stages are plain delay registers. An empty stage always
// advances, so bubbles close up behind a stalled output.
module fround_pipe
  import fpu_pkg::*;
#(
  parameter int NSTAGE = 2,
  parameter int TAGW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_x,
  input  logic [1:0]      in_mode,
  input  logic [TAGW-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_y,
  output logic            out_inexact,
  output logic [TAGW-1:0] out_tag
);

  logic [NSTAGE-1:0] valid_q, valid_d;
  logic [NSTAGE-1:0] inx_q, inx_d;
  logic [NSTAGE-1:0] adv_s;
  logic [31:0]       y_q   [NSTAGE];
  logic [31:0]       y_d   [NSTAGE];
  logic [TAGW-1:0]   tag_q [NSTAGE];
  logic [TAGW-1:0]   tag_d [NSTAGE];
  logic [31:0]       calc_y_s;
  logic              calc_inx_s;
  logic              accept_s;

  fround_calc u_calc (
    .x       (in_x),
    .mode    (round_mode_e'(in_mode)),
    .y       (calc_y_s),
    .inexact (calc_inx_s)
  );

  assign in_ready    = !valid_q[NSTAGE-1] || out_ready;
  assign accept_s    = in_valid && in_ready;
  assign out_valid   = valid_q[NSTAGE-1];
  assign out_y       = y_q[NSTAGE-1];
  assign out_inexact = inx_q[NSTAGE-1];
  assign out_tag     = tag_q[NSTAGE-1];

  // A stage may load when it is empty or everything downstream moves
  always_comb begin : adv_chain
    logic go_v;
    go_v = out_ready;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      go_v     = go_v || !valid_q[i];
      adv_s[i] = go_v;
    end
  end

  // Next-state for every stage: load from upstream when advancing, else hold
  always_comb begin
    valid_d = valid_q;
    inx_d   = inx_q;
    y_d     = y_q;
    tag_d   = tag_q;
    if (adv_s[0]) begin
      valid_d[0] = accept_s;
      if (accept_s) begin
        y_d[0]   = calc_y_s;
        inx_d[0] = calc_inx_s;
        tag_d[0] = in_tag;
      end else begin
        y_d[0] = y_q[0];
      end
    end else begin
      valid_d[0] = valid_q[0];
    end
    for (int i = 1; i < NSTAGE; i++) begin
      if (adv_s[i]) begin
        valid_d[i] = valid_q[i-1];
        if (valid_q[i-1]) begin
          y_d[i]   = y_q[i-1];
          inx_d[i] = inx_q[i-1];
          tag_d[i] = tag_q[i-1];
        end else begin
          y_d[i] = y_q[i];
        end
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
  end

  // Stage registers; reset empties the pipe and zeroes the payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {NSTAGE{1'b0}};
      inx_q   <= {NSTAGE{1'b0}};
      for (int i = 0; i < NSTAGE; i++) begin
        y_q[i]   <= 32'd0;
        tag_q[i] <= {TAGW{1'b0}};
      end
    end else begin
      valid_q <= valid_d;
      inx_q   <= inx_d;
      for (int i = 0; i < NSTAGE; i++) begin
        y_q[i]   <= y_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

endmodule

// File: tb/tb_fround_pipe.sv
// Bench for fround_pipe: directed corner cases, backpressure, mid-flight
// reset and a random sweep against a real-arithmetic reference model.
module tb_fround_pipe;

  localparam int NSTAGE = 2;
  localparam int TAGW   = 4;

  typedef struct {
    logic [31:0]     y;
    logic            inx;
    logic [TAGW-1:0] tag;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_x;
  logic [1:0]      in_mode;
  logic [TAGW-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_y;
  logic            out_inexact;
  logic [TAGW-1:0] out_tag;

  int          n_cmp   = 0;
  int          n_bad   = 0;
  int          out_cnt = 0;
  logic [31:0] nxt_y;
  logic        nxt_inx;
  exp_t        sb_q[$];
  logic        rnd_done;

  always #5 clk = ~clk;

  fround_pipe #(.NSTAGE(NSTAGE), .TAGW(TAGW)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_mode     (in_mode),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_y       (out_y),
    .out_inexact (out_inexact),
    .out_tag     (out_tag)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, want);
    end
  endtask

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) begin
      for (int i = 0; i < k; i++) r = r * 2.0;
    end else begin
      for (int i = 0; i < -k; i++) r = r / 2.0;
    end
    return r;
  endfunction

  // Reference: decode to a real, round with $floor/$ceil, re-encode.
  function automatic void ref_round(input logic [31:0] x, input logic [1:0] mode,
                                    output logic [31:0] y, output logic inx);
    logic       s;
    int         e;
    int         m;
    real        v, r, d, mag;
    int         ex;
    longint     mant;
    logic [7:0] ex8;
    logic [22:0] m23;
    s = x[31];
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    inx = 1'b0;
    if (e == 255) begin
      y = (m != 0) ? (x | 32'h0040_0000) : x;
      return;
    end
    if (e >= 150) begin
      y = x;
      return;
    end
    if (e == 0) begin
      y = {s, 31'd0};
      inx = (m != 0);
      return;
    end
    v = (1.0 + real'(m) / 8388608.0) * pow2(e - 127);
    if (s) v = -v;
    case (mode)
      2'd0: r = $floor(v);
      2'd1: r = $ceil(v);
      2'd2: r = (v < 0.0) ? $ceil(v) : $floor(v);
      default: begin
        r = $floor(v);
        d = v - r;
        if (d > 0.5 || (d == 0.5 && ($floor(r / 2.0) * 2.0 != r))) r = r + 1.0;
      end
    endcase
    inx = (r != v);
    if (r == 0.0) begin
      y = {s, 31'd0};
      return;
    end
    mag = (r < 0.0) ? -r : r;
    ex = 127;
    while (mag >= 2.0) begin
      mag = mag / 2.0;
      ex++;
    end
    mant = longint'((mag - 1.0) * 8388608.0);
    ex8 = 8'(ex);
    m23 = 23'(mant);
    y = {s, ex8, m23};
  endfunction

  function automatic logic [31:0] rand_x();
    logic        s;
    logic [7:0]  e;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) e = 8'($urandom_range(0, 255));
    else e = 8'($urandom_range(110, 152));
    m = 23'($urandom);
    if ($urandom_range(0, 2) == 0) m = m & (23'h7F_FFFF << $urandom_range(0, 22));
    return {s, e, m};
  endfunction

  // Scoreboard: record accepted operands and compare released results,
  // sampled just before the rising edge at which the handshakes fire.
  always @(negedge clk) begin
    #4;
    if (!rst) begin
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          check("y", out_y, e.y);
          check("inexact", 32'(out_inexact), 32'(e.inx));
          check("tag", 32'(out_tag), 32'(e.tag));
        end
        out_cnt++;
      end
      if (in_valid && in_ready) begin
        exp_t n;
        n.y = nxt_y;
        n.inx = nxt_inx;
        n.tag = in_tag;
        sb_q.push_back(n);
      end
    end
  end

  task automatic send(input logic [31:0] x, input logic [1:0] m, input logic [TAGW-1:0] t,
                      input logic [31:0] ey, input logic einx, output int waits);
    @(negedge clk);
    in_valid = 1'b1;
    in_x = x;
    in_mode = m;
    in_tag = t;
    nxt_y = ey;
    nxt_inx = einx;
    waits = 0;
    #1;
    while (!in_ready && waits < 200) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic send_rand(input logic [TAGW-1:0] t);
    logic [31:0] x, ey;
    logic [1:0]  m;
    logic        einx;
    int          w;
    x = rand_x();
    m = 2'($urandom_range(0, 3));
    ref_round(x, m, ey, einx);
    send(x, m, t, ey, einx, w);
  endtask

  task automatic drain();
    int g;
    @(negedge clk);
    in_valid = 1'b0;
    g = 0;
    while (sb_q.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  logic [31:0] dx   [14] = '{32'hBE99999A, 32'h4B800001, 32'h7F800001, 32'h3E99999A,
                             32'hBE99999A, 32'hBE99999A, 32'h3F000000, 32'h3F000001,
                             32'h00000001, 32'h80000001, 32'hFF800000, 32'h3FC00000,
                             32'h40100000, 32'h4AFFFFFF};
  logic [1:0]  dm   [14] = '{2'd1, 2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd3,
                             2'd1, 2'd0, 2'd0, 2'd3, 2'd1, 2'd3};
  logic [31:0] dy   [14] = '{32'h80000000, 32'h4B800001, 32'h7FC00001, 32'h3F800000,
                             32'hBF800000, 32'h80000000, 32'h00000000, 32'h3F800000,
                             32'h00000000, 32'h80000000, 32'hFF800000, 32'h40000000,
                             32'h40400000, 32'h4B000000};
  logic        dinx [14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, lat, cnt0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_x = 32'd0;
    in_mode = 2'd0;
    in_tag = '0;
    out_ready = 1'b1;
    nxt_y = 32'd0;
    nxt_inx = 1'b0;
    rnd_done = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_y", out_y, 32'd0);
    check("rst_inexact", 32'(out_inexact), 32'd0);
    check("rst_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // floor(-1.5) and its latency
    send(32'hBFC00000, 2'd0, 4'hA, 32'hC0000000, 1'b1, w);
    lat = 0;
    for (int k = 1; k <= NSTAGE + 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), 32'(NSTAGE));
    check("floor_m1p5_y", out_y, 32'hC0000000);
    check("floor_m1p5_inx", 32'(out_inexact), 32'd1);
    drain();

    // ties to even, back-to-back
    send(32'h40200000, 2'd3, 4'h1, 32'h40000000, 1'b1, w);
    send(32'h40600000, 2'd3, 4'h2, 32'h40800000, 1'b1, w);
    check("b2b_wait", 32'(w), 32'd0);
    drain();

    // boundary table
    for (int i = 0; i < 14; i++) send(dx[i], dm[i], TAGW'(i), dy[i], dinx[i], w);
    drain();

    // backpressure with a full pipe
    cnt0 = out_cnt;
    fork
      begin
        for (int i = 0; i < 10; i++) send_rand(TAGW'(i));
      end
      begin
        repeat (4) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          out_ready = 1'b0;
          #1;
          check("bp_in_ready", 32'(in_ready), 32'd0);
          check("bp_out_valid", 32'(out_valid), 32'd1);
          if (sb_q.size() != 0) begin
            check("bp_hold_y", out_y, sb_q[0].y);
            check("bp_hold_tag", 32'(out_tag), 32'(sb_q[0].tag));
          end else begin
            check("bp_sb_nonempty", 32'(sb_q.size()), 32'd1);
          end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 32'(out_cnt - cnt0), 32'd10);

    // reset with two operands in flight
    send_rand(4'h5);
    send_rand(4'h6);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NSTAGE + 2; k++) begin
      @(negedge clk);
      #1;
      check("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    // random sweep with random gaps and backpressure
    fork
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 4) == 0) begin
            @(negedge clk);
            in_valid = 1'b0;
          end
          send_rand(TAGW'($urandom));
        end
        rnd_done = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
